divider_cp_dp: RTL and testbench

//  Iterative radix-2 restoring divider for the RV32M accelerator: DIV, DIVU, REM, REMU.
//  It is the inverse companion of the multiplier control/datapath pair and has the same start/done handshake.
//  It sits beside the multiplier under the M-unit top. The top drives div_en_i from decode and consumes result_o on done_o.

---
 rtl/divider_cp_dp.sv | 214 +++++++++++++++++++++
 tb/tb_divider_cp_dp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_cp_dp.sv
// -----------------------------------------------------------------------------
// divider_cp_dp
//   Iterative radix-2 restoring divider (control FSM + datapath) for the RV32M
//   M-unit: DIV, DIVU, REM, REMU. It uses the same start/done handshake as the
//   multiplier pair it sits beside.
//
//   Signed operations divide operand magnitudes. The signs are then applied in
//   a single FIX cycle. One quotient bit is produced per DIVIDE cycle.
//
// Ports
//   clk_i       in   1      single clock, rising edge
//   rst_i       in   1      synchronous, active-high reset
//   div_en_i    in   1      start request, sampled only in IDLE
//   op_i        in   2      00=DIV 01=DIVU 10=REM 11=REMU, sampled with div_en_i
//   dividend_i  in   WIDTH  rs1, sampled with div_en_i
//   divisor_i   in   WIDTH  rs2, sampled with div_en_i
//   busy_o      out  1      high in every state except IDLE
//   done_o      out  1      one-cycle pulse; result_o is valid
//   result_o    out  WIDTH  quotient or remainder; held until the next done_o
//
// Optional feature
//   DIV_FAST_SPECIAL_EN: when this macro is defined, a divide-by-zero or a
//   signed overflow goes directly from IDLE to DONE. The result is the same as
//   on the full path; only the latency is shorter.
// -----------------------------------------------------------------------------
module divider_cp_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             div_en_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_a_q, neg_a_d;     // signed op and dividend negative
    logic             neg_b_q, neg_b_d;     // signed op and divisor negative
    logic             dvsr_zero_q, dvsr_zero_d;

    // Operand conditioning at the accept edge. Negating the most negative
    // value leaves it at 0x8000...0. Read as unsigned, that is the correct
    // magnitude.
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // A single restoring step. The shifted partial remainder can be WIDTH+1
    // bits wide, so the subtraction is one bit wider than the operands. Its
    // top bit is the borrow.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Sign correction applied in FIX.
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

`ifdef DIV_FAST_SPECIAL_EN
    logic             special_zero;
    logic             special_ovf;
    logic [WIDTH-1:0] special_quo;
    logic [WIDTH-1:0] special_rem;
`endif

    always_comb begin
        signed_op = ~op_i[0];
        a_neg     = signed_op & dividend_i[WIDTH-1];
        b_neg     = signed_op & divisor_i[WIDTH-1];
        a_mag     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
        b_mag     = b_neg ? (~divisor_i + 1'b1) : divisor_i;

        shifted   = {rem_q, quo_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvsr_q};

        // With a zero divisor, every trial succeeds. The quotient then becomes
        // all ones and the remainder becomes |a|. Restoring the dividend sign
        // gives back the original dividend, so only the quotient negation
        // must be suppressed.
        if (dvsr_zero_q) begin
            quo_fixed = '1;
        end else if (neg_a_q ^ neg_b_q) begin
            quo_fixed = ~quo_q + 1'b1;
        end else begin
            quo_fixed = quo_q;
        end
        rem_fixed = neg_a_q ? (~rem_q + 1'b1) : rem_q;
    end

`ifdef DIV_FAST_SPECIAL_EN
    always_comb begin
        special_zero = (divisor_i == '0);
        special_ovf  = signed_op
                     && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                     && (divisor_i == '1);
        special_quo  = special_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
        special_rem  = special_zero ? dividend_i : '0;
    end
`endif

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        result_d    = result_q;
        is_rem_d    = is_rem_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        dvsr_zero_d = dvsr_zero_q;

        case (state_q)
            S_IDLE: begin
                if (div_en_i) begin
                    is_rem_d    = op_i[1];
                    neg_a_d     = a_neg;
                    neg_b_d     = b_neg;
                    dvsr_zero_d = (divisor_i == '0);
                    quo_d       = a_mag;
                    dvsr_d      = b_mag;
                    rem_d       = '0;
                    count_d     = '0;
                    state_d     = S_DIVIDE;
`ifdef DIV_FAST_SPECIAL_EN
                    if (special_zero || special_ovf) begin
                        result_d = op_i[1] ? special_rem : special_quo;
                        state_d  = S_DONE;
                    end
`endif
                end
            end

            S_DIVIDE: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                result_d = is_rem_q ? rem_fixed : quo_fixed;
                state_d  = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            result_q    <= '0;
            is_rem_q    <= 1'b0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            dvsr_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            result_q    <= result_d;
            is_rem_q    <= is_rem_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            dvsr_zero_q <= dvsr_zero_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_divider_cp_dp.sv
// -----------------------------------------------------------------------------
// tb_divider_cp_dp
//   Self-checking bench for divider_cp_dp.
//
//   A table of vectors is applied one operation at a time. Each expected
//   result, together with the latency it must have, is queued when the
//   operation is accepted. A negedge monitor pops the queue on each done_o and
//   compares. Hand-written sequences then cover:
//     - mid-operation reset,
//     - input changes while the divider is busy,
//     - back-to-back operations with div_en_i held high.
// -----------------------------------------------------------------------------
module tb_divider_cp_dp;

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam int FULL_LAT = 34;   // negedges from E0 to the done_o sample

    logic        clk = 1'b0;
    logic        rst_i;
    logic        div_en_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    divider_cp_dp #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .div_en_i   (div_en_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        int          start;
        int          lat;
        bit          chk_lat;
    } sb_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    sb_t  sb[$];
    sb_t  cur;
    vec_t vecs[14];

    int tests     = 0;
    int fails     = 0;
    int ncnt      = 0;
    int last_done = -1;
    int prev_done = -1;

    // Scoreboard monitor: runs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        ncnt++;
        if (done_o) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: done_o=1 with no op outstanding, result_o=%h", result_o);
            end else begin
                cur = sb.pop_front();
                if (result_o !== cur.exp) begin
                    fails++;
                    $display("FAIL result: got %h expected %h", result_o, cur.exp);
                end
                if (cur.chk_lat) begin
                    tests++;
                    if (ncnt - cur.start != cur.lat) begin
                        fails++;
                        $display("FAIL latency: got %0d expected %0d", ncnt - cur.start, cur.lat);
                    end
                end
                $display("[TB] done result=%h expected=%h", result_o, cur.exp);
            end
            prev_done = last_done;
            last_done = ncnt;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Call this #1 after a rising edge with the DUT in IDLE. It returns at
    // the negedge following the accept edge E0.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input int lat);
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        div_en_i   = 1'b1;
        @(posedge clk);
        sb.push_back('{exp: exp, start: ncnt, lat: lat, chk_lat: 1'b1});
        #1;
        div_en_i   = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        op_i       = 2'($urandom_range(0, 3));
        $display("[TB] start op=%0d a=%h b=%h expect=%h", op, a, b, exp);
        @(negedge clk);
        check("busy_after_e0", {31'b0, busy_o}, 32'd1);
    endtask

    // Waits until every queued result has been seen. A missing done_o counts
    // as a failure. Returns #1 after a rising edge.
    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
        vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
        vecs[5]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
        vecs[6]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[7]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1'b1};
        vecs[8]  = '{2'b01, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[11] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1};
        vecs[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[13] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};

        rst_i      = 1'b1;
        div_en_i   = 1'b0;
        op_i       = 2'b00;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   {31'b0, busy_o}, 32'd0);
        check("reset_done",   {31'b0, done_o}, 32'd0);
        check("reset_result", result_o,        32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                     (FAST && vecs[i].special) ? 1 : FULL_LAT);
            drain();
        end
        check("idle_after_done", {31'b0, busy_o}, 32'd0);

        // Reset at E10 aborts the operation and produces no done_o.
        start_op(2'b01, 32'd100, 32'd7, 32'd14, FULL_LAT);
        repeat (9) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_busy",   {31'b0, busy_o}, 32'd0);
        check("abort_done",   {31'b0, done_o}, 32'd0);
        check("abort_result", result_o,        32'd0);
        @(posedge clk);
        #1;
        start_op(2'b01, 32'd9, 32'd3, 32'd3, FULL_LAT);
        drain();

        // Input activity while busy has no effect: exactly one done_o, with
        // result 14.
        start_op(2'b01, 32'd100, 32'd7, 32'd14, FULL_LAT);
        repeat (5) @(posedge clk);
        #1;
        div_en_i   = 1'b1;
        op_i       = 2'b10;
        dividend_i = 32'd12345;
        divisor_i  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        div_en_i = 1'b0;
        drain();
        repeat (40) @(posedge clk);
        #1;

        // div_en_i held high: back-to-back operations, with done_o pulses 35
        // cycles apart.
        op_i       = 2'b01;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        div_en_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{exp: 32'd14, start: 0, lat: 0, chk_lat: 1'b0});
        end
        begin
            int k;
            k = 0;
            while (sb.size() != 0 && k < 300) begin
                @(posedge clk);
                k++;
            end
        end
        #1;
        div_en_i = 1'b0;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL held_timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
        check("held_spacing", 32'(last_done - prev_done), 32'd35);
        repeat (40) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
